// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run/step/halt sequencer.
//  - run_state_t  : sequencer state encoding as presented on state_o
//  - halt_cause_t : stop cause encoding as presented on halt_cause_o
//  - HALT_INSN_DEF, CNT_W_DEF : default parameter values
//  - is_terminal / is_resumable : classify a stop cause
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_RUN     = 2'd2,
        S_STOPPED = 2'd3
    } run_state_t;

    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_EXT   = 3'd1,
        C_HALT  = 3'd2,
        C_BP    = 3'd3,
        C_LIMIT = 3'd4
    } halt_cause_t;

    localparam logic [31:0] HALT_INSN_DEF = 32'hFFFF_FFFF;
    localparam int          CNT_W_DEF     = 32;

    // Program is finished: only a fresh start leaves STOPPED.
    function automatic logic is_terminal(input halt_cause_t cause);
        return (cause == C_HALT) || (cause == C_LIMIT);
    endfunction

    // Execution may continue with resume or step.
    function automatic logic is_resumable(input halt_cause_t cause);
        return (cause == C_EXT) || (cause == C_BP);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter used for the cycle and stall counts.
// Ports:
//  clk  in  1      clock, rising edge
//  rst  in  1      synchronous active-high reset to zero
//  clr  in  1      synchronous clear to zero (wins over inc)
//  inc  in  1      count up by one, holding at all-ones
//  q    out CNT_W  current count (registered)
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count register: reset/clear first, then increment unless already saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + ONE;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle CPU.
// Gates datapath progress through cpu_en_o, issues a one-cycle clear pulse,
// and stops on external halt, halt instruction, PC breakpoint or cycle budget.
// Ports:
//  clk_i, rst_i             clock and synchronous active-high reset
//  start_i                  (re)start program through CLEAR from any state
//  halt_i                   external stop request, sampled in RUN
//  step_i, resume_i         single-step / resume while STOPPED (resumable causes)
//  bp_en_i, bp_addr_i       PC breakpoint
//  cycle_limit_i            enabled-cycle budget, 0 = unlimited
//  pc_i, instr_i            current PC and instruction from the CPU
//  cpu_en_o                 CPU advances this cycle (combinational)
//  cpu_clr_o                one-cycle datapath clear
//  state_o, halt_cause_o    sequencer state and stop cause
//  done_o                   stopped on a terminal cause
//  cycle_cnt_o, stall_cnt_o enabled-cycle and stopped-cycle counts since CLEAR
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_INSN = HALT_INSN_DEF,
    parameter int          CNT_W     = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             halt_i,
    input  logic             step_i,
    input  logic             resume_i,
    input  logic             bp_en_i,
    input  logic [31:0]      bp_addr_i,
    input  logic [CNT_W-1:0] cycle_limit_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      instr_i,
    output logic             cpu_en_o,
    output logic             cpu_clr_o,
    output logic [1:0]       state_o,
    output logic [2:0]       halt_cause_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    run_state_t  state_r, state_n_s;
    halt_cause_t cause_r, cause_n_s, stop_cause_s;
    logic        skip_bp_r, skip_bp_n_s;
    logic        done_r, clr_r;
    logic        en_s, limit_hit_s, cnt_clr_s, stall_inc_s;
    logic [CNT_W-1:0] cycle_cnt_s, stall_cnt_s;

    // Stop check on the current instruction, highest priority cause first.
    always_comb begin
        limit_hit_s = (cycle_limit_i != '0) && (cycle_cnt_s == cycle_limit_i);
        if (halt_i) begin
            stop_cause_s = C_EXT;
        end else if (instr_i == HALT_INSN) begin
            stop_cause_s = C_HALT;
        end else if (bp_en_i && (pc_i == bp_addr_i) && !skip_bp_r) begin
            stop_cause_s = C_BP;
        end else if (limit_hit_s) begin
            stop_cause_s = C_LIMIT;
        end else begin
            stop_cause_s = C_NONE;
        end
    end

    // Next-state, cause, breakpoint-skip and CPU enable decode.
    always_comb begin
        state_n_s   = state_r;
        cause_n_s   = cause_r;
        skip_bp_n_s = skip_bp_r;
        en_s        = 1'b0;
        if (rst_i) begin
            // Datapath frozen during reset; registers reload in always_ff.
            en_s = 1'b0;
        end else if (start_i) begin
            state_n_s   = S_CLEAR;
            cause_n_s   = C_NONE;
            skip_bp_n_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_n_s = S_IDLE;
                end
                S_CLEAR: begin
                    state_n_s   = S_RUN;
                    cause_n_s   = C_NONE;
                    skip_bp_n_s = 1'b0;
                end
                S_RUN: begin
                    if (stop_cause_s != C_NONE) begin
                        // Offending instruction is held, not executed.
                        state_n_s = S_STOPPED;
                        cause_n_s = stop_cause_s;
                    end else begin
                        en_s        = 1'b1;
                        skip_bp_n_s = 1'b0;
                    end
                end
                S_STOPPED: begin
                    if (resume_i && is_resumable(cause_r)) begin
                        // Skip lets the breakpointed instruction execute once.
                        state_n_s   = S_RUN;
                        skip_bp_n_s = 1'b1;
                    end else if (step_i && is_resumable(cause_r) && !limit_hit_s) begin
                        en_s = 1'b1;
                    end else begin
                        en_s = 1'b0;
                    end
                end
                default: begin
                    state_n_s = S_IDLE;
                end
            endcase
        end
    end

    // Sequencer registers and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= S_IDLE;
            cause_r   <= C_NONE;
            skip_bp_r <= 1'b0;
            done_r    <= 1'b0;
            clr_r     <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            cause_r   <= cause_n_s;
            skip_bp_r <= skip_bp_n_s;
            done_r    <= (state_n_s == S_STOPPED) && is_terminal(cause_n_s);
            clr_r     <= (state_n_s == S_CLEAR);
        end
    end

    // Clearing on the start edge makes counters read zero during CLEAR.
    assign cnt_clr_s   = start_i || (state_r == S_CLEAR);
    assign stall_inc_s = (state_r == S_STOPPED);

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .clr (cnt_clr_s),
        .inc (en_s),
        .q   (cycle_cnt_s)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .clr (cnt_clr_s),
        .inc (stall_inc_s),
        .q   (stall_cnt_s)
    );

    assign cpu_en_o     = en_s;
    assign cpu_clr_o    = clr_r;
    assign state_o      = state_r;
    assign halt_cause_o = cause_r;
    assign done_o       = done_r;
    assign cycle_cnt_o  = cycle_cnt_s;
    assign stall_cnt_o  = stall_cnt_s;

endmodule
